edge_filter_bank: RTL and testbench

EDGE_FILTER_BANK -- requirements
Module: edge_filter_bank

---
 rtl/edge_filter_bank.sv | 117 +++++++++++
 tb/tb_edge_filter_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_filter_bank.sv
// edge_filter_bank: a bank of independent channels. Each channel synchronises
// a raw asynchronous input and debounces it, accepting a new level only after
// it has been seen for FILT_CYCLES consecutive cycles. It reports mode-selected
// edges as a one-cycle pulse and as a sticky pending flag with overrun detection.
// irq is the OR of all pending flags.
module edge_filter_bank #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   sgn,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]   clr,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   out,
   output logic [CHANNELS-1:0]   pending,
   output logic [CHANNELS-1:0]   ovf,
   output logic                  irq
);

   // The counter only has to reach FILT_CYCLES-1, and it keeps at least one bit.
   localparam int               CNT_W   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

   localparam logic [1:0] MODE_POS  = 2'b00;
   localparam logic [1:0] MODE_NEG  = 2'b01;
   localparam logic [1:0] MODE_BOTH = 2'b10;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] chain;
      logic                   synced;
      logic [CNT_W-1:0]       cnt;
      logic                   lvl_q;
      logic                   out_q;
      logic                   pnd_q;
      logic                   ovf_q;
      logic                   differs;
      logic                   take;
      logic                   hit;
      logic [1:0]             ch_mode;

      assign synced  = chain[SYNC_STAGES-1];
      assign ch_mode = mode[2*i +: 2];

      if (SYNC_STAGES == 1) begin : g_sync_one
         // Single synchroniser flop.
         always_ff @(posedge clk) begin
            if (rst) chain <= 1'b0;
            else     chain <= sgn[i];
         end
      end else begin : g_sync_many
         // Shift the raw input down the synchroniser chain. The chain is reset
         // so that a level already high across reset is filtered again.
         always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so that every
            // flop samples values from before the edge, whatever the block order.
            if (rst) chain <= '0;
            else     chain <= {chain[SYNC_STAGES-2:0], sgn[i]};
         end
      end

      // Decide whether this edge accepts a new level and whether that is a reported event.
      always_comb begin
         // NOTE: every output of this block is given a default first, so no path
         // leaves it unassigned and no latch is inferred.
         differs = synced ^ lvl_q;
         take    = differs && (cnt == CNT_MAX);
         hit     = 1'b0;
         unique case (ch_mode)
            MODE_POS:  hit = take &&  synced;
            MODE_NEG:  hit = take && !synced;
            MODE_BOTH: hit = take;
            default:   hit = 1'b0;
         endcase
      end

      // Filter counter, accepted level and the registered event pulse.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt   <= '0;
            lvl_q <= 1'b0;
            out_q <= 1'b0;
         end else begin
            if (!differs) begin
               cnt <= '0;
            end else if (take) begin
               cnt   <= '0;
               lvl_q <= synced;
            end else begin
               cnt <= cnt + 1'b1;
            end
            out_q <= hit;
         end
      end

      // Sticky pending and overrun flags. A new event has priority over clr.
      always_ff @(posedge clk) begin
         if (rst) begin
            pnd_q <= 1'b0;
            ovf_q <= 1'b0;
         end else begin
            pnd_q <= out_q | (pnd_q & ~clr[i]);
            ovf_q <= (out_q & pnd_q) | (ovf_q & ~clr[i]);
         end
      end

      assign level[i]   = lvl_q;
      assign out[i]     = out_q;
      assign pending[i] = pnd_q;
      assign ovf[i]     = ovf_q;
   end

   assign irq = |pending;

endmodule

// File: tb/tb_edge_filter_bank.sv
// tb_edge_filter_bank: drives two instances (default parameters, and an
// 8-channel build with one sync stage and one filter cycle). Every cycle it
// compares all outputs of both instances against a queue-based reference model.
module tb_edge_filter_bank;

   logic        clk = 1'b0;
   logic        rst;

   logic [3:0]  a_sgn, a_clr, a_level, a_out, a_pending, a_ovf;
   logic [7:0]  a_mode;
   logic        a_irq;

   logic [7:0]  b_sgn, b_clr, b_level, b_out, b_pending, b_ovf;
   logic [15:0] b_mode;
   logic        b_irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   edge_filter_bank dut_a (
      .clk     (clk),
      .rst     (rst),
      .sgn     (a_sgn),
      .mode    (a_mode),
      .clr     (a_clr),
      .level   (a_level),
      .out     (a_out),
      .pending (a_pending),
      .ovf     (a_ovf),
      .irq     (a_irq)
   );

   edge_filter_bank #(.CHANNELS(8), .SYNC_STAGES(1), .FILT_CYCLES(1)) dut_b (
      .clk     (clk),
      .rst     (rst),
      .sgn     (b_sgn),
      .mode    (b_mode),
      .clr     (b_clr),
      .level   (b_level),
      .out     (b_out),
      .pending (b_pending),
      .ovf     (b_ovf),
      .irq     (b_irq)
   );

   // Reference model: per channel, a queue of raw samples in flight through the
   // synchroniser and a window of the last FILT_CYCLES synced values. The level
   // flips once the whole window disagrees with it.
   bit       syn_q [2][8][$];
   bit       win_q [2][8][$];
   logic [7:0] m_lvl [2] = '{8'h00, 8'h00};
   logic [7:0] m_out [2] = '{8'h00, 8'h00};
   logic [7:0] m_pnd [2] = '{8'h00, 8'h00};
   logic [7:0] m_ovf [2] = '{8'h00, 8'h00};

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_step(input int d, input int nch, input int ss, input int ff,
                             input bit r, input logic [7:0] s, input logic [15:0] m,
                             input logic [7:0] c);
      logic [7:0] lvl_n;
      logic [7:0] out_n;
      lvl_n = m_lvl[d];
      out_n = 8'h00;
      for (int i = 0; i < nch; i++) begin
         bit         synced;
         bit         flip;
         logic [1:0] mi;
         if (r) begin
            syn_q[d][i].delete();
            for (int k = 0; k < ss; k++) syn_q[d][i].push_back(1'b0);
            win_q[d][i].delete();
            continue;
         end
         synced = syn_q[d][i][0];
         syn_q[d][i].push_back(s[i]);
         void'(syn_q[d][i].pop_front());
         win_q[d][i].push_back(synced);
         if (win_q[d][i].size() > ff) void'(win_q[d][i].pop_front());
         flip = (win_q[d][i].size() == ff);
         for (int k = 0; k < win_q[d][i].size(); k++)
            if (win_q[d][i][k] == m_lvl[d][i]) flip = 1'b0;
         if (flip) begin
            lvl_n[i] = ~m_lvl[d][i];
            mi       = m[2*i +: 2];
            out_n[i] = (mi == 2'b10) || (mi == 2'b00 && lvl_n[i]) || (mi == 2'b01 && !lvl_n[i]);
         end
      end
      if (r) begin
         m_lvl[d] = 8'h00;
         m_out[d] = 8'h00;
         m_pnd[d] = 8'h00;
         m_ovf[d] = 8'h00;
      end else begin
         m_ovf[d] = (m_out[d] & m_pnd[d]) | (m_ovf[d] & ~c);
         m_pnd[d] = m_out[d] | (m_pnd[d] & ~c);
         m_lvl[d] = lvl_n;
         m_out[d] = out_n;
      end
   endtask

   // Advance the model with the inputs present before the edge, clock once, compare.
   task automatic tick();
      model_step(0, 4, 2, 4, rst, {4'h0, a_sgn}, {8'h00, a_mode}, {4'h0, a_clr});
      model_step(1, 8, 1, 1, rst, b_sgn, b_mode, b_clr);
      @(posedge clk);
      #1;
      check("a_level",   {4'h0, a_level},   m_lvl[0]);
      check("a_out",     {4'h0, a_out},     m_out[0]);
      check("a_pending", {4'h0, a_pending}, m_pnd[0]);
      check("a_ovf",     {4'h0, a_ovf},     m_ovf[0]);
      check("a_irq",     {7'h00, a_irq},    {7'h00, |m_pnd[0]});
      check("b_level",   b_level,           m_lvl[1]);
      check("b_out",     b_out,             m_out[1]);
      check("b_pending", b_pending,         m_pnd[1]);
      check("b_ovf",     b_ovf,             m_ovf[1]);
      check("b_irq",     {7'h00, b_irq},    {7'h00, |m_pnd[1]});
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int budget;
      rst    = 1'b1;
      a_sgn  = '0; a_mode = '0; a_clr = '0;
      b_sgn  = '0; b_mode = '0; b_clr = '0;
      @(negedge clk);
      ticks(3);
      rst = 1'b0;

      // Clean rising edge on ch0, mode pos: level and pulse 6 edges later.
      a_sgn[0] = 1'b1;
      ticks(10);

      // Three-cycle glitch on ch1 must be swallowed.
      a_sgn[1] = 1'b1;
      ticks(3);
      a_sgn[1] = 1'b0;
      ticks(8);

      // ch2 falling-edge mode; ch3 disabled but level still tracks.
      a_mode[5:4] = 2'b01;
      a_mode[7:6] = 2'b11;
      a_sgn[2] = 1'b1; a_sgn[3] = 1'b1; ticks(8);
      a_sgn[2] = 1'b0; a_sgn[3] = 1'b0; ticks(8);
      a_sgn[2] = 1'b1; a_sgn[3] = 1'b1; ticks(8);
      a_sgn[3] = 1'b0; ticks(7);

      // Overrun on ch0 (both edges), then clr colliding with a new event.
      a_mode[1:0] = 2'b10;
      a_clr = 4'hF; tick(); a_clr = 4'h0;
      a_sgn[0] = 1'b0; ticks(8);
      a_sgn[0] = 1'b1; ticks(8);
      a_sgn[0] = 1'b0;
      budget = 0;
      while (m_out[0][0] !== 1'b1 && budget < 12) begin
         tick();
         budget++;
      end
      check("a_evt_seen", {7'h00, a_out[0]}, 8'h01);
      a_clr[0] = 1'b1; tick();
      a_clr[0] = 1'b0; tick();
      a_clr = 4'hF; tick();
      a_clr = 4'h0; tick();

      // Reset in the middle of a filter count with the input held high.
      a_mode = 8'h00;
      a_sgn  = 4'h0; ticks(8);
      a_sgn  = 4'h1; ticks(4);
      rst = 1'b1; ticks(2);
      rst = 1'b0; ticks(10);

      // All eight channels of the fast instance toggled together, both edges.
      b_mode = 16'hAAAA;
      for (int r = 0; r < 4; r++) begin
         b_sgn = ~b_sgn;
         ticks(4);
      end

      // Randomised traffic on both instances.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(7) == 0) a_sgn[i] = ~a_sgn[i];
         for (int i = 0; i < 8; i++)
            if ($urandom_range(3) == 0) b_sgn[i] = ~b_sgn[i];
         if ($urandom_range(49) == 0) a_mode = 8'($urandom);
         if ($urandom_range(49) == 0) b_mode = 16'($urandom);
         for (int i = 0; i < 4; i++) a_clr[i] = ($urandom_range(11) == 0);
         for (int i = 0; i < 8; i++) b_clr[i] = ($urandom_range(11) == 0);
         rst = ($urandom_range(399) == 0);
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
